tc_int_arbiter: RTL and testbench

//  Downstream consumer of the timer/counter interrupt_request lines. Collects level requests

---
 rtl/tc_pkg.sv | 12 +
 rtl/tc_prio_enc.sv | 20 ++
 rtl/tc_int_arbiter.sv | 126 ++++++++++++
 tb/tb_tc_int_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// Shared timer/counter interrupt definitions: arbiter FSM states and the vector map
// constants that sit next to the timer interrupt mask/flag registers.
package tc_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} tcint_state_t;

  localparam logic [7:0] A_TIFR      = 8'h38;
  localparam logic [7:0] A_TIMSK     = 8'h39;
  localparam logic [7:0] TC_VEC_BASE = 8'h20;
  localparam int         TC_VEC_STEP = 2;

endpackage

// File: rtl/tc_prio_enc.sv
// Lowest-set-bit encoder: bit 0 is the highest priority. Pure combinational, all-zero gives valid=0.
module tc_prio_enc #(
  parameter int NSRC  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NSRC-1:0]  req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
    valid = |req;
  end

endmodule

// File: rtl/tc_int_arbiter.sv
// Fixed-priority interrupt arbiter between the timer/counter request lines and the CPU.
// Issues one winner at a time, returns the CPU ack to that source, then blanks for HOLD_CYC clocks.
module tc_int_arbiter
  import tc_pkg::*;
#(
  parameter int               NSRC     = 4,
  parameter int               VEC_W    = 8,
  parameter logic [VEC_W-1:0] VEC_BASE = TC_VEC_BASE,
  parameter int               VEC_STEP = TC_VEC_STEP,
  parameter int               HOLD_CYC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NSRC-1:0]  src_req,
  input  logic             sreg_i,
  input  logic             cpu_ack,
  output logic [NSRC-1:0]  src_ack,
  output logic             cpu_irq,
  output logic [VEC_W-1:0] cpu_vector,
  output logic             busy
);

  localparam int IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int CNT_W = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
  localparam int WIDE_W = VEC_W + 8;

  tcint_state_t     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NSRC-1:0]  src_ack_q, src_ack_d;
  logic             cpu_irq_q, cpu_irq_d;
  logic [VEC_W-1:0] cpu_vector_q, cpu_vector_d;
  logic             busy_q, busy_d;

  logic [IDX_W-1:0]  enc_idx;
  logic              enc_valid;
  logic [WIDE_W-1:0] vec_wide;

  tc_prio_enc #(
    .NSRC  (NSRC),
    .IDX_W (IDX_W)
  ) u_enc (
    .req   (src_req),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    src_ack_d    = '0;
    cpu_irq_d    = cpu_irq_q;
    cpu_vector_d = cpu_vector_q;
    vec_wide     = WIDE_W'(VEC_BASE) + WIDE_W'(enc_idx) * WIDE_W'(VEC_STEP);

    unique case (state_q)
      IDLE: begin
        cpu_irq_d = 1'b0;
        if (sreg_i && enc_valid) begin
          idx_d        = enc_idx;
          cpu_vector_d = vec_wide[VEC_W-1:0];
          cpu_irq_d    = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        // The ack is honoured even if the request was withdrawn in the same cycle.
        if (cpu_ack) begin
          src_ack_d = NSRC'(1) << idx_q;
          cpu_irq_d = 1'b0;
          if (HOLD_CYC == 0) begin
            state_d = IDLE;
          end else begin
            cnt_d   = CNT_W'(HOLD_CYC);
            state_d = HOLD;
          end
        end else if (!sreg_i || !src_req[idx_q]) begin
          cpu_irq_d = 1'b0;
          state_d   = IDLE;
        end
      end
      HOLD: begin
        cpu_irq_d = 1'b0;
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        cpu_irq_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      src_ack_q    <= '0;
      cpu_irq_q    <= 1'b0;
      cpu_vector_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      src_ack_q    <= src_ack_d;
      cpu_irq_q    <= cpu_irq_d;
      cpu_vector_q <= cpu_vector_d;
      busy_q       <= busy_d;
    end
  end

  assign src_ack    = src_ack_q;
  assign cpu_irq    = cpu_irq_q;
  assign cpu_vector = cpu_vector_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_tc_int_arbiter.sv
// Directed-vector bench for tc_int_arbiter with hand-computed expectations.
module tb_tc_int_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] src_req;
  logic       sreg_i;
  logic       cpu_ack;
  logic [3:0] src_ack;
  logic       cpu_irq;
  logic [7:0] cpu_vector;
  logic       busy;

  int total;
  int bad;

  tc_int_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .src_req    (src_req),
    .sreg_i     (sreg_i),
    .cpu_ack    (cpu_ack),
    .src_ack    (src_ack),
    .cpu_irq    (cpu_irq),
    .cpu_vector (cpu_vector),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold3();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_irq", 32'(cpu_irq), 32'd0);
      chk("hold_ack", 32'(src_ack), 32'd0);
    end
  endtask

  initial begin
    logic seen_irq;
    int   d;
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    src_req = '0;
    sreg_i  = 1'b0;
    cpu_ack = 1'b0;
    #12;
    chk("rst_irq", 32'(cpu_irq), 32'd0);
    chk("rst_vec", 32'(cpu_vector), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(src_ack), 32'd0);
    step();
    rst = 1'b0;
    step();

    // 1: single source 0
    src_req = 4'b0001; sreg_i = 1'b1;
    step();
    chk("t1_irq", 32'(cpu_irq), 32'd1);
    chk("t1_vec", 32'(cpu_vector), 32'h20);
    chk("t1_busy", 32'(busy), 32'd1);
    cpu_ack = 1'b1;
    step();
    cpu_ack = 1'b0; src_req = '0;
    chk("t1_ack", 32'(src_ack), 32'b0001);
    chk("t1_irq_off", 32'(cpu_irq), 32'd0);
    hold3();
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: simultaneous 0110 -> idx1, then idx2
    src_req = 4'b0110;
    step();
    chk("t2_vec1", 32'(cpu_vector), 32'h22);
    cpu_ack = 1'b1;
    step();
    cpu_ack = 1'b0; src_req = 4'b0100;
    chk("t2_ack1", 32'(src_ack), 32'b0010);
    hold3();
    step();
    chk("t2_irq2", 32'(cpu_irq), 32'd1);
    chk("t2_vec2", 32'(cpu_vector), 32'h24);

    // 4: no preemption by idx0 while idx2 is issued
    src_req = 4'b0101;
    step();
    chk("t4_irq", 32'(cpu_irq), 32'd1);
    chk("t4_vec", 32'(cpu_vector), 32'h24);
    cpu_ack = 1'b1;
    step();
    cpu_ack = 1'b0; src_req = 4'b0001;
    chk("t4_ack2", 32'(src_ack), 32'b0100);
    hold3();
    step();
    chk("t4_vec0", 32'(cpu_vector), 32'h20);
    cpu_ack = 1'b1;
    step();
    cpu_ack = 1'b0; src_req = '0;
    chk("t4_ack0", 32'(src_ack), 32'b0001);
    hold3();

    // 3: masked request stays pending
    sreg_i = 1'b0; src_req = 4'b1000;
    seen_irq = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cpu_irq) seen_irq = 1'b1;
    end
    chk("t3_masked", 32'(seen_irq), 32'd0);
    sreg_i = 1'b1;
    step();
    chk("t3_irq", 32'(cpu_irq), 32'd1);
    chk("t3_vec", 32'(cpu_vector), 32'h26);

    // 5: withdraw via sreg_i, then via request drop
    sreg_i = 1'b0;
    step();
    chk("t5a_irq", 32'(cpu_irq), 32'd0);
    chk("t5a_ack", 32'(src_ack), 32'd0);
    chk("t5a_busy", 32'(busy), 32'd0);
    sreg_i = 1'b1;
    step();
    chk("t5b_irq", 32'(cpu_irq), 32'd1);
    src_req = '0;
    step();
    chk("t5b_irq_off", 32'(cpu_irq), 32'd0);
    chk("t5b_ack", 32'(src_ack), 32'd0);
    chk("t5b_busy", 32'(busy), 32'd0);

    // ack outside ISSUE is ignored
    cpu_ack = 1'b1;
    step();
    cpu_ack = 1'b0;
    chk("stray_ack", 32'(src_ack), 32'd0);
    chk("stray_busy", 32'(busy), 32'd0);

    // ack wins over a simultaneous withdraw
    src_req = 4'b0010;
    step();
    chk("aw_vec", 32'(cpu_vector), 32'h22);
    cpu_ack = 1'b1; src_req = '0;
    step();
    cpu_ack = 1'b0;
    chk("aw_ack", 32'(src_ack), 32'b0010);
    hold3();

    // 6: repeated requests with random ack delay, one src_ack each
    for (int n = 0; n < 5; n++) begin
      src_req = 4'b1000;
      step();
      chk("r_irq", 32'(cpu_irq), 32'd1);
      d = $urandom_range(0, 7);
      for (int k = 0; k < d; k++) begin
        step();
        chk("r_wait_ack", 32'(src_ack), 32'd0);
      end
      chk("r_vec", 32'(cpu_vector), 32'h26);
      cpu_ack = 1'b1;
      step();
      cpu_ack = 1'b0; src_req = '0;
      chk("r_ack", 32'(src_ack), 32'b1000);
      hold3();
    end

    // reset mid-ISSUE clears outputs immediately, no ack emitted
    src_req = 4'b0100;
    step();
    chk("rm_irq", 32'(cpu_irq), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rm_irq_off", 32'(cpu_irq), 32'd0);
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_vec", 32'(cpu_vector), 32'd0);
    cpu_ack = 1'b1;
    step();
    chk("rm_ack", 32'(src_ack), 32'd0);
    cpu_ack = 1'b0;
    rst = 1'b0;
    step();
    chk("post_rst_irq", 32'(cpu_irq), 32'd1);
    chk("post_rst_vec", 32'(cpu_vector), 32'h24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
